// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared sizes and types for the three-port SDRAM arbiter.
package sdram_arb_pkg;
  localparam int NPORT = 3;
  localparam int AW    = 26;
  localparam int DW    = 16;
  localparam int BW    = 2;
  localparam int RW    = 64;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  // One port's transaction fields as captured at grant time.
  typedef struct packed {
    logic          wr;
    logic          burst;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [BW-1:0] bs;
  } req_t;
endpackage

// File: rtl/sdram_arb_rr.sv
// sdram_arb_rr: grant selector. Port 0 (CPU) has fixed priority. Ports 1 and 2
// share a round-robin based on which of them was served last.
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req,
  input  logic             grant_en,
  output logic             gnt_valid,
  output logic [1:0]       gnt_idx
);

  // last1 = 1 means port 1 was served last, so port 2 wins a 1-vs-2 tie.
  logic last1_q, last1_d;

  // Pick the winner: port 0 first, otherwise the port not served last.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 2'd0;
    if (req[0]) begin
      gnt_idx = 2'd0;
    end else if (req[1] && req[2]) begin
      gnt_idx = last1_q ? 2'd2 : 2'd1;
    end else if (req[1]) begin
      gnt_idx = 2'd1;
    end else if (req[2]) begin
      gnt_idx = 2'd2;
    end
  end

  // Move the pointer only when port 1 or 2 actually receives a grant.
  always_comb begin
    last1_d = last1_q;
    if (grant_en && gnt_valid && (gnt_idx != 2'd0)) begin
      last1_d = (gnt_idx == 2'd1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1_q <= 1'b0;
    end else begin
      last1_q <= last1_d;
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: three-port arbiter in front of a single-request SDRAM controller.
// One transaction at a time: IDLE (grant) -> ISSUE -> WAIT -> DONE (ack).
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      nRESET,
  input  logic [NPORT-1:0]          p_req,
  input  logic [NPORT-1:0]          p_wr,
  input  logic [NPORT-1:0]          p_burst,
  input  logic [NPORT-1:0][AW-1:0]  p_addr,
  input  logic [NPORT-1:0][DW-1:0]  p_din,
  input  logic [NPORT-1:0][BW-1:0]  p_bs,
  output logic [NPORT-1:0]          p_ack,
  output logic                      p_err,
  output logic [RW-1:0]             rdata,
  output logic                      sd_sel,
  output logic                      sd_rd,
  output logic                      sd_wr,
  output logic                      sd_burst,
  output logic [AW-1:0]             sd_addr,
  output logic [DW-1:0]             sd_din,
  output logic [BW-1:0]             sd_bs,
  input  logic                      sd_ready,
  input  logic [RW-1:0]             sd_dout
);

  state_e             state_q, state_d;
  req_t               req_q, req_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               err_q, err_d;
  logic [RW-1:0]      rdata_q, rdata_d;

  logic               gnt_valid;
  logic [1:0]         gnt_idx;
  logic               limit_hit;
  logic               xfer_done;
  logic               abort;

  sdram_arb_rr u_rr (
    .clk       (clk),
    .rst_n     (nRESET),
    .req       (p_req),
    .grant_en  (state_q == IDLE),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A normal completion in the final budget cycle beats the abort.
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign limit_hit = (cnt_inc == CNT_W'(TIMEOUT));
  assign xfer_done = (state_q == WAIT) && sd_ready;
  assign abort     = ((state_q == ISSUE) || (state_q == WAIT)) && limit_hit && !xfer_done;

  // Next-state logic for the transaction FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ISSUE;
      ISSUE: begin
        if (abort)          state_d = DONE;
        else if (!sd_ready) state_d = WAIT;
      end
      WAIT:    if (xfer_done || abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner at grant, count ISSUE/WAIT cycles, capture read data.
  always_comb begin
    req_d   = req_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          req_d.wr    = p_wr[gnt_idx];
          req_d.burst = p_burst[gnt_idx];
          req_d.addr  = p_addr[gnt_idx];
          req_d.din   = p_din[gnt_idx];
          req_d.bs    = p_bs[gnt_idx];
          gnt_d       = gnt_idx;
          cnt_d       = '0;
          err_d       = 1'b0;
        end
      end
      ISSUE, WAIT: begin
        cnt_d = cnt_inc;
        if (abort) err_d = 1'b1;
        if (xfer_done && !req_q.wr) rdata_d = sd_dout;
      end
      default: ;
    endcase
  end

  // Controller handshake and port acknowledge decoded from the current state.
  always_comb begin
    sd_sel   = 1'b0;
    sd_rd    = 1'b0;
    sd_wr    = 1'b0;
    sd_burst = 1'b0;
    p_ack    = '0;
    p_err    = 1'b0;
    case (state_q)
      ISSUE: begin
        sd_sel   = 1'b1;
        sd_rd    = ~req_q.wr;
        sd_wr    = req_q.wr;
        sd_burst = req_q.burst & ~req_q.wr;
      end
      WAIT: sd_sel = 1'b1;
      DONE: begin
        p_ack = NPORT'(1) << gnt_q;
        p_err = err_q;
      end
      default: ;
    endcase
    sd_addr = req_q.addr;
    sd_din  = req_q.din;
    sd_bs   = req_q.bs;
    rdata   = rdata_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      req_q   <= '0;
      gnt_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed scenarios for the SDRAM arbiter. A small controller
// model answers the main instance; a second instance with TIMEOUT=15 sees a
// controller that never drops ready.
module tb_sdram_arb;
  import sdram_arb_pkg::*;

  logic                     clk;
  logic                     nRESET;
  logic [NPORT-1:0]         p_req, p_wr, p_burst;
  logic [NPORT-1:0][AW-1:0] p_addr;
  logic [NPORT-1:0][DW-1:0] p_din;
  logic [NPORT-1:0][BW-1:0] p_bs;
  logic [NPORT-1:0]         p_ack;
  logic                     p_err;
  logic [RW-1:0]            rdata;
  logic                     sd_sel, sd_rd, sd_wr, sd_burst;
  logic [AW-1:0]            sd_addr;
  logic [DW-1:0]            sd_din;
  logic [BW-1:0]            sd_bs;
  logic                     sd_ready;
  logic [RW-1:0]            sd_dout;

  logic [NPORT-1:0]         to_req;
  logic [NPORT-1:0]         to_ack;
  logic                     to_err;
  logic [RW-1:0]            to_rdata;
  logic                     to_sel, to_rd, to_wr, to_burst;
  logic [AW-1:0]            to_addr;
  logic [DW-1:0]            to_din;
  logic [BW-1:0]            to_bs;
  logic                     to_ready;
  logic [RW-1:0]            to_dout;

  int errors = 0;
  int checks = 0;

  int            m_acc  = 1;
  int            m_busy = 6;
  logic [RW-1:0] m_dout = '0;

  sdram_arb dut (
    .clk(clk), .nRESET(nRESET), .p_req(p_req), .p_wr(p_wr), .p_burst(p_burst),
    .p_addr(p_addr), .p_din(p_din), .p_bs(p_bs), .p_ack(p_ack), .p_err(p_err),
    .rdata(rdata), .sd_sel(sd_sel), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_burst(sd_burst), .sd_addr(sd_addr), .sd_din(sd_din), .sd_bs(sd_bs),
    .sd_ready(sd_ready), .sd_dout(sd_dout)
  );

  sdram_arb #(.TIMEOUT(15)) dut_to (
    .clk(clk), .nRESET(nRESET), .p_req(to_req), .p_wr(p_wr), .p_burst(p_burst),
    .p_addr(p_addr), .p_din(p_din), .p_bs(p_bs), .p_ack(to_ack), .p_err(to_err),
    .rdata(to_rdata), .sd_sel(to_sel), .sd_rd(to_rd), .sd_wr(to_wr),
    .sd_burst(to_burst), .sd_addr(to_addr), .sd_din(to_din), .sd_bs(to_bs),
    .sd_ready(to_ready), .sd_dout(to_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: after seeing a request, keep ready high m_acc cycles,
  // then drop it for m_busy cycles and raise it again with m_dout.
  initial begin
    int mst;
    int mcnt;
    mst      = 0;
    mcnt     = 0;
    sd_ready = 1'b1;
    sd_dout  = '0;
    forever begin
      @(negedge clk);
      if (!nRESET) begin
        mst      = 0;
        sd_ready = 1'b1;
      end else begin
        case (mst)
          0: if (sd_sel && (sd_rd || sd_wr)) begin
               mcnt = m_acc;
               mst  = 1;
             end
          1: begin
               mcnt--;
               if (mcnt <= 0) begin
                 sd_ready = 1'b0;
                 mcnt     = m_busy;
                 mst      = 2;
               end
             end
          2: begin
               mcnt--;
               if (mcnt <= 0) begin
                 sd_ready = 1'b1;
                 sd_dout  = m_dout;
                 mst      = 3;
               end
             end
          default: if (!sd_sel) mst = 0;
        endcase
      end
    end
  end

  task automatic wait_ack(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (p_ack != '0) seen = 1'b1;
    end
  endtask

  task automatic wait_sel(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sd_sel) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    nRESET   = 1'b0;
    p_req    = '0;
    p_wr     = '0;
    p_burst  = '0;
    p_addr   = '0;
    p_din    = '0;
    p_bs     = '0;
    to_req   = '0;
    to_ready = 1'b1;
    to_dout  = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (3) @(negedge clk);
    checks++;
    if ({p_ack, p_err, sd_sel, sd_rd, sd_wr, sd_burst} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {p_ack, p_err, sd_sel, sd_rd, sd_wr, sd_burst});
    end
    checks++;
    if ({sd_addr, sd_din, sd_bs} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %h expected 0", {sd_addr, sd_din, sd_bs});
    end
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h expected 0", rdata);
    end
    nRESET = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({p_ack, sd_sel} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %b expected 0", {p_ack, sd_sel});
    end
  endtask

  task automatic test_single_read();
    bit seen;
    m_acc  = 1;
    m_busy = 6;
    m_dout = 64'h1122334455667788;
    p_wr[2]    = 1'b0;
    p_burst[2] = 1'b0;
    p_addr[2]  = 26'h0001000;
    p_req[2]   = 1'b1;
    wait_ack(40, seen);
    p_req[2] = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL read_timeout: got no ack expected ack within 40 cycles");
    end
    checks++;
    if (p_ack !== 3'b100 || p_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_ack: got ack=%b err=%b expected ack=100 err=0", p_ack, p_err);
    end
    checks++;
    if (rdata !== 64'h1122334455667788) begin
      errors++;
      $display("[TB] FAIL read_data: got %h expected 1122334455667788", rdata);
    end
    @(negedge clk);
    checks++;
    if (p_ack !== 3'b000 || rdata !== 64'h1122334455667788 || sd_addr !== 26'h0001000) begin
      errors++;
      $display("[TB] FAIL read_after: got ack=%b rdata=%h addr=%h expected 000/1122334455667788/0001000", p_ack, rdata, sd_addr);
    end
  endtask

  task automatic test_round_robin();
    int order[6];
    int exp_order[6];
    int hold[3];
    int n;
    int idx;
    exp_order = '{0, 1, 0, 2, 0, 1};
    hold      = '{0, 0, 0};
    n         = 0;
    m_acc     = 1;
    m_busy    = 1;
    p_wr      = '0;
    p_burst   = '0;
    p_addr[0] = 26'h0000010;
    p_addr[1] = 26'h0000020;
    p_addr[2] = 26'h0000030;
    p_req     = 3'b111;
    for (int cyc = 0; cyc < 400 && n < 6; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          if (hold[i] == 0) p_req[i] = 1'b1;
        end
      end
      if (p_ack != '0) begin
        case (p_ack)
          3'b001:  idx = 0;
          3'b010:  idx = 1;
          3'b100:  idx = 2;
          default: idx = -1;
        endcase
        order[n] = idx;
        n++;
        if (idx >= 0) begin
          p_req[idx] = 1'b0;
          hold[idx]  = 2;
        end
      end
    end
    p_req = '0;
    checks++;
    if (n != 6) begin
      errors++;
      $display("[TB] FAIL rr_count: got %0d acks expected 6", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: got port %0d expected port %0d", i, order[i], exp_order[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_burst_inflight();
    bit seen;
    m_acc  = 2;
    m_busy = 3;
    m_dout = 64'hA5A5_0000_FFFF_1234;
    p_wr[1]    = 1'b0;
    p_burst[1] = 1'b1;
    p_addr[1]  = 26'h2ABCDEF;
    p_req[1]   = 1'b1;
    wait_sel(20, seen);
    checks++;
    if (!seen || {sd_rd, sd_wr, sd_burst} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL burst_issue: got sel=%b rd/wr/burst=%b expected 1/101", seen, {sd_rd, sd_wr, sd_burst});
    end
    p_addr[1] = 26'h0000000;
    p_wr[1]   = 1'b1;
    p_req[0]  = 1'b0;
    @(negedge clk);
    checks++;
    if (sd_addr !== 26'h2ABCDEF || sd_wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_stable: got addr=%h wr=%b expected 2abcdef/0", sd_addr, sd_wr);
    end
    wait_ack(40, seen);
    p_req[1] = 1'b0;
    p_wr[1]  = 1'b0;
    checks++;
    if (!seen || p_ack !== 3'b010 || rdata !== 64'hA5A5_0000_FFFF_1234) begin
      errors++;
      $display("[TB] FAIL burst_done: got ack=%b rdata=%h expected 010/a5a50000ffff1234", p_ack, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_write_refresh();
    bit seen;
    int wr_cycles;
    bit bad_fields;
    seen       = 1'b0;
    wr_cycles  = 0;
    bad_fields = 1'b0;
    m_acc  = 20;
    m_busy = 2;
    m_dout = 64'h0BAD_0BAD_0BAD_0BAD;
    p_wr[1]    = 1'b1;
    p_burst[1] = 1'b1;
    p_addr[1]  = 26'h1234567;
    p_din[1]   = 16'hBEEF;
    p_bs[1]    = 2'b10;
    p_req[1]   = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (sd_wr) begin
        wr_cycles++;
        if (sd_bs !== 2'b10 || sd_burst !== 1'b0 || sd_din !== 16'hBEEF || sd_rd !== 1'b0) bad_fields = 1'b1;
      end
      if (p_ack != '0) seen = 1'b1;
    end
    p_req[1] = 1'b0;
    checks++;
    if (wr_cycles < 20) begin
      errors++;
      $display("[TB] FAIL write_hold: got %0d cycles of sd_wr expected at least 20", wr_cycles);
    end
    checks++;
    if (bad_fields) begin
      errors++;
      $display("[TB] FAIL write_fields: got wrong bs/burst/din during sd_wr expected bs=10 burst=0 din=beef");
    end
    checks++;
    if (!seen || p_ack !== 3'b010 || p_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_ack: got ack=%b err=%b expected 010/0", p_ack, p_err);
    end
    checks++;
    if (rdata !== 64'hA5A5_0000_FFFF_1234) begin
      errors++;
      $display("[TB] FAIL write_rdata: got %h expected a5a50000ffff1234", rdata);
    end
    p_wr[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit seen;
    int rd_cycles;
    logic [NPORT-1:0] ack_s;
    logic err_s, rd_s, sel_s;
    seen      = 1'b0;
    rd_cycles = 0;
    ack_s     = '0;
    err_s     = 1'b0;
    rd_s      = 1'b1;
    sel_s     = 1'b1;
    p_wr[0]    = 1'b0;
    p_burst[0] = 1'b0;
    p_addr[0]  = 26'h0000444;
    to_req     = 3'b001;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (to_rd) rd_cycles++;
      if (to_ack != '0) begin
        seen  = 1'b1;
        ack_s = to_ack;
        err_s = to_err;
        rd_s  = to_rd;
        sel_s = to_sel;
      end
    end
    to_req = '0;
    checks++;
    if (rd_cycles != 15) begin
      errors++;
      $display("[TB] FAIL timeout_len: got %0d cycles of sd_rd expected 15", rd_cycles);
    end
    checks++;
    if (!seen || ack_s !== 3'b001 || err_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_ack: got ack=%b err=%b expected 001/1", ack_s, err_s);
    end
    checks++;
    if (rd_s !== 1'b0 || sel_s !== 1'b0 || to_rdata !== 64'h0) begin
      errors++;
      $display("[TB] FAIL timeout_outs: got rd=%b sel=%b rdata=%h expected 0/0/0", rd_s, sel_s, to_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_drop_in_issue();
    bit seen;
    m_acc  = 3;
    m_busy = 2;
    m_dout = 64'h0000_0000_0000_5555;
    p_wr[0]   = 1'b0;
    p_addr[0] = 26'h0000777;
    p_req[0]  = 1'b1;
    wait_sel(20, seen);
    p_req[0] = 1'b0;
    checks++;
    if (!seen || sd_rd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_issue: got sel=%b rd=%b expected 1/1", seen, sd_rd);
    end
    wait_ack(40, seen);
    checks++;
    if (!seen || p_ack !== 3'b001 || rdata !== 64'h5555) begin
      errors++;
      $display("[TB] FAIL drop_ack: got ack=%b rdata=%h expected 001/5555", p_ack, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    bit seen;
    int acks;
    seen = 1'b0;
    acks = 0;
    m_acc  = 1;
    m_busy = 10;
    m_dout = 64'h7777_7777_7777_7777;
    p_wr[0]   = 1'b0;
    p_addr[0] = 26'h0000ABC;
    p_din[0]  = 16'h1357;
    p_bs[0]   = 2'b11;
    p_req[0]  = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (sd_sel && !sd_rd && !sd_wr) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL rst_reach_wait: got no WAIT expected WAIT within 30 cycles");
    end
    nRESET   = 1'b0;
    p_req[0] = 1'b0;
    #1;
    checks++;
    if ({p_ack, p_err, sd_sel, sd_rd, sd_wr, sd_burst} !== 8'b0 || rdata !== 64'h0) begin
      errors++;
      $display("[TB] FAIL rst_outs: got ctrl=%b rdata=%h expected 0/0", {p_ack, p_err, sd_sel, sd_rd, sd_wr, sd_burst}, rdata);
    end
    checks++;
    if ({sd_addr, sd_din, sd_bs} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_hold: got %h expected 0", {sd_addr, sd_din, sd_bs});
    end
    repeat (3) @(negedge clk);
    nRESET = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (p_ack != '0) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("[TB] FAIL rst_no_ack: got %0d acks expected 0", acks);
    end
    m_busy = 2;
    m_dout = 64'h0123_4567_89AB_CDEF;
    p_req[0] = 1'b1;
    wait_ack(40, seen);
    p_req[0] = 1'b0;
    checks++;
    if (!seen || p_ack !== 3'b001 || p_err !== 1'b0 || rdata !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("[TB] FAIL rst_recover: got ack=%b err=%b rdata=%h expected 001/0/0123456789abcdef", p_ack, p_err, rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_inflight();
    test_write_refresh();
    test_timeout();
    test_drop_in_issue();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
